// File: rtl/swiss_timer_ctrl.sv
// Stopwatch controller: start/stop and lap/clear FSM, 10 ms prescaler and
// a BCD mm:ss.cc chain with a lap latch and sticky overflow flag.
module swiss_timer_ctrl #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_stop,
  input  logic        lap_clear,
  output logic [23:0] disp_digits,
  output logic        running,
  output logic        lap_hold,
  output logic        overflow
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [23:0]     cnt_q, cnt_d, cnt_inc;
  logic [23:0]     lap_q, lap_d;
  logic            run_q, run_d;
  logic            hold_q, hold_d;
  logic            ovf_q, ovf_d;
  logic            counting, tick, wrap, capture, clear;

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (presc_q == PW'(TICK_DIV - 1));

  // Ripple increment across all six digits in one step; tens of seconds
  // and tens of minutes wrap after 5, every other digit after 9.
  always_comb begin
    logic       carry;
    logic [3:0] lim;
    cnt_inc = cnt_q;
    carry   = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        if (cnt_q[i*4 +: 4] >= lim) begin
          cnt_inc[i*4 +: 4] = 4'd0;
        end else begin
          cnt_inc[i*4 +: 4] = cnt_q[i*4 +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: if (start_stop) state_d = RUN;
      RUN: begin
        if (start_stop) begin
          state_d = STOP;
        end else if (lap_clear) begin
          state_d = LAP;
          capture = 1'b1;
        end
      end
      LAP: begin
        if (start_stop)     state_d = STOP;
        else if (lap_clear) state_d = RUN;
      end
      STOP: begin
        if (start_stop) begin
          state_d = RUN;
        end else if (lap_clear) begin
          state_d = IDLE;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    run_d  = (state_d == RUN) || (state_d == LAP);
    hold_d = (state_d == LAP);

    // Prescaler holds in STOP so a resume finishes the partial interval.
    presc_d = presc_q;
    if (clear)         presc_d = '0;
    else if (tick)     presc_d = '0;
    else if (counting) presc_d = presc_q + 1'b1;

    cnt_d = cnt_q;
    if (clear)     cnt_d = '0;
    else if (tick) cnt_d = cnt_inc;

    ovf_d = ovf_q;
    if (clear)             ovf_d = 1'b0;
    else if (tick && wrap) ovf_d = 1'b1;

    lap_d = capture ? cnt_q : lap_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      lap_q   <= '0;
      run_q   <= 1'b0;
      hold_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
    end
  end

  assign disp_digits = hold_q ? lap_q : cnt_q;
  assign running     = run_q;
  assign lap_hold    = hold_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_swiss_timer_ctrl.sv
// Bench for swiss_timer_ctrl: directed scenarios plus random pulses, all
// compared against a centisecond-integer reference model.
module tb_swiss_timer_ctrl;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        lap_clear = 1'b0;
  logic [23:0] disp_digits;
  logic        running, lap_hold, overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: elapsed time as integer centiseconds, modes as flags.
  int m_cs, m_lap, m_presc;
  bit m_run, m_hold, m_stop, m_ovf;

  swiss_timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_stop (start_stop),
    .lap_clear  (lap_clear),
    .disp_digits(disp_digits),
    .running    (running),
    .lap_hold   (lap_hold),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int cs);
    int c, s, m;
    c = cs % 100;
    s = (cs / 100) % 60;
    m = cs / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic model_reset();
    m_cs = 0; m_lap = 0; m_presc = 0;
    m_run = 0; m_hold = 0; m_stop = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit ss, input bit lc);
    bit tick;
    int old_cs;
    old_cs = m_cs;
    tick   = m_run && (m_presc == TD - 1);
    if (m_run) m_presc = tick ? 0 : m_presc + 1;
    if (tick) begin
      m_cs++;
      if (m_cs == 360000) begin
        m_cs  = 0;
        m_ovf = 1;
      end
    end
    if (!m_run && !m_stop) begin
      if (ss) m_run = 1;
    end else if (m_run && !m_hold) begin
      if (ss) begin m_run = 0; m_stop = 1; end
      else if (lc) begin m_hold = 1; m_lap = old_cs; end
    end else if (m_hold) begin
      if (ss) begin m_run = 0; m_hold = 0; m_stop = 1; end
      else if (lc) m_hold = 0;
    end else begin
      if (ss) begin m_run = 1; m_stop = 0; end
      else if (lc) begin m_stop = 0; m_cs = 0; m_presc = 0; m_ovf = 0; end
    end
  endtask

  task automatic compare_all();
    check("disp", disp_digits, m_hold ? to_bcd(m_lap) : to_bcd(m_cs));
    check("running", 24'(running), 24'(m_run));
    check("lap_hold", 24'(lap_hold), 24'(m_hold));
    check("overflow", 24'(overflow), 24'(m_ovf));
  endtask

  task automatic cycle(input bit ss, input bit lc);
    start_stop = ss;
    lap_clear  = lc;
    @(posedge clk);
    model_step(ss, lc);
    #1;
    start_stop = 1'b0;
    lap_clear  = 1'b0;
    compare_all();
  endtask

  // Called at posedge+1: asserts reset between edges, pulses while held.
  task automatic async_reset(input string tag);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_disp0"}, disp_digits, 24'h000000);
    check({tag, "_run0"}, 24'(running), 24'd0);
    check({tag, "_hold0"}, 24'(lap_hold), 24'd0);
    check({tag, "_ovf0"}, 24'(overflow), 24'd0);
    start_stop = 1'b1;
    lap_clear  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start_stop = 1'b0;
    lap_clear  = 1'b0;
    reset_n    = 1'b1;
  endtask

  initial begin
    int r;
    bit ss, lc;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_disp", disp_digits, 24'h000000);
    check("rst_running", 24'(running), 24'd0);
    check("rst_hold", 24'(lap_hold), 24'd0);
    check("rst_ovf", 24'(overflow), 24'd0);
    reset_n = 1'b1;

    // One second run, freeze, clear.
    cycle(1, 0);
    repeat (400) cycle(0, 0);
    check("sec_disp", disp_digits, 24'h000100);
    check("sec_running", 24'(running), 24'd1);
    cycle(1, 0);
    repeat (10) cycle(0, 0);
    check("stop_frozen", disp_digits, 24'h000100);
    check("stop_running", 24'(running), 24'd0);
    cycle(0, 1);
    check("clear_disp", disp_digits, 24'h000000);

    // Resume with prescaler at 2: next tick exactly 2 clk later.
    cycle(1, 0);
    cycle(0, 0);
    cycle(1, 0);
    repeat (5) cycle(0, 0);
    cycle(1, 0);
    cycle(0, 0);
    check("resume_1clk", disp_digits, 24'h000000);
    cycle(0, 0);
    check("resume_2clk", disp_digits, 24'h000001);
    cycle(1, 0);
    cycle(0, 1);

    // Lap hold while live count advances.
    cycle(1, 0);
    repeat (48) cycle(0, 0);
    check("lap_pre", disp_digits, 24'h000012);
    cycle(0, 1);
    check("lap_hold_on", 24'(lap_hold), 24'd1);
    repeat (20) cycle(0, 0);
    check("lap_frozen", disp_digits, 24'h000012);
    check("lap_running", 24'(running), 24'd1);
    cycle(0, 1);
    check("lap_release", 24'(lap_hold), 24'd0);
    check("live_gt12", 24'(disp_digits > 24'h000012), 24'd1);

    // Simultaneous pulses in RUN: stop wins, no capture.
    cycle(1, 1);
    check("both_running", 24'(running), 24'd0);
    check("both_hold", 24'(lap_hold), 24'd0);
    cycle(0, 1);

    // Overflow: preload 59:59.98 while stopped.
    cycle(1, 0);
    cycle(0, 0);
    cycle(1, 0);
    force dut.cnt_q = 24'h595998;
    m_cs = 359998;
    #1;
    cycle(0, 0);
    release dut.cnt_q;
    cycle(0, 0);
    check("preload", disp_digits, 24'h595998);
    cycle(1, 0);
    for (int i = 0; i < 3 * TD && m_cs != 359999; i++) cycle(0, 0);
    check("ovf_595999", disp_digits, 24'h595999);
    check("ovf_not_yet", 24'(overflow), 24'd0);
    for (int i = 0; i < 3 * TD && m_cs != 0; i++) cycle(0, 0);
    check("ovf_wrap", disp_digits, 24'h000000);
    check("ovf_set", 24'(overflow), 24'd1);
    repeat (TD) cycle(0, 0);
    check("ovf_sticky", 24'(overflow), 24'd1);
    cycle(1, 0);
    cycle(0, 1);
    check("ovf_cleared", 24'(overflow), 24'd0);

    // Asynchronous reset mid-LAP.
    cycle(1, 0);
    repeat (10) cycle(0, 0);
    cycle(0, 1);
    repeat (3) cycle(0, 0);
    async_reset("lap_rst");
    repeat (10) cycle(0, 0);
    check("post_rst_disp", disp_digits, 24'h000000);
    check("post_rst_running", 24'(running), 24'd0);

    // Random pulses, including coincident ones and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      ss = (r < 4) || (r == 9);
      lc = (r >= 4 && r < 9) || (r == 9);
      if ($urandom_range(0, 999) == 0) async_reset("rnd_rst");
      cycle(ss, lc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
